// File: rtl/period_meter_if.sv
// Result bundle of the period meter: measured period and high time,
// a one-cycle valid strobe and the sticky stall flag.
interface period_meter_if #(
    parameter int W = 16
);
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         stalled;

    modport master (
        output period,
        output high_time,
        output valid,
        output stalled
    );

    modport slave (
        input period,
        input high_time,
        input valid,
        input stalled
    );
endinterface

// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous periodic input,
// counted in clk_in cycles, with a sticky stall flag on timeout.
module period_meter #(
    parameter int W       = 16,
    parameter int MAX_CNT = 2**W - 1
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           sig_in,
    period_meter_if.master res_o
);
    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    localparam logic [W-1:0] MAX_V = W'(MAX_CNT);
    localparam logic [W-1:0] ONE   = W'(1);

    state_e       state_q, state_d;
    logic         s1_q, s2_q, sd_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    logic [W-1:0] hlat_q, hlat_d;
    logic         seen_q, seen_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         stall_q, stall_d;
    logic         rise, fall;

    assign rise = s2_q & ~sd_q;
    assign fall = ~s2_q & sd_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sd_q     <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            hlat_q   <= '0;
            seen_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            sd_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            hlat_q   <= hlat_d;
            seen_q   <= seen_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        hlat_d   = hlat_q;
        seen_d   = seen_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                hcnt_d = '0;
                if (rise) begin
                    cnt_d   = ONE;
                    hcnt_d  = ONE;
                    seen_d  = 1'b0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle still counts as a valid period.
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = seen_q ? hlat_q : hcnt_q;
                    valid_d  = 1'b1;
                    stall_d  = 1'b0;
                    cnt_d    = ONE;
                    hcnt_d   = ONE;
                    seen_d   = 1'b0;
                end else if (cnt_q == MAX_V) begin
                    stall_d = 1'b1;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (s2_q) begin
                        hcnt_d = hcnt_q + ONE;
                    end
                    if (fall) begin
                        hlat_d = hcnt_q;
                        seen_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_o.period    = period_q;
    assign res_o.high_time = high_q;
    assign res_o.valid     = valid_q;
    assign res_o.stalled   = stall_q;
endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances with timeouts of
// 100, 20 and 50 cycles, each driven by directed waveforms.
module tb_period_meter;
    typedef struct {
        int p;
        int h;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sig = 3'b000;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    bit   armed[3];
    int   ph[3];
    int   pl[3];
    int   rise_k[3];

    period_meter_if #(.W(16)) ifa ();
    period_meter_if #(.W(16)) ifb ();
    period_meter_if #(.W(16)) ifc ();

    period_meter #(.W(16), .MAX_CNT(100)) u_a (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig[0]), .res_o(ifa)
    );
    period_meter #(.W(16), .MAX_CNT(20)) u_b (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig[1]), .res_o(ifb)
    );
    period_meter #(.W(16), .MAX_CNT(50)) u_c (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig[2]), .res_o(ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic pop(input int d, input int p, input int h);
        exp_t e;
        int   sz;
        sz = (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid[%0d]: got period %0d high %0d expected none (cycle %0d)",
                     d, p, h, cyc);
        end else begin
            case (d)
                0: e = qa.pop_front();
                1: e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            chk($sformatf("period[%0d]", d), p, e.p);
            chk($sformatf("high_time[%0d]", d), h, e.h);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.valid) pop(0, int'(ifa.period), int'(ifa.high_time));
        if (ifb.valid) pop(1, int'(ifb.period), int'(ifb.high_time));
        if (ifc.valid) pop(2, int'(ifc.period), int'(ifc.high_time));
    end

    task automatic push(input int d, input int p, input int h);
        exp_t e;
        e.p = p;
        e.h = h;
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Raise sig[d]; a rise completes the previous period if one was open.
    task automatic do_rise(input int d, input int hi, input int lo);
        sig[d] = 1'b1;
        rise_k[d] = cyc + 1;
        if (armed[d]) push(d, ph[d] + pl[d], ph[d]);
        armed[d] = 1'b1;
        ph[d] = hi;
        pl[d] = lo;
    endtask

    task automatic run(input int d, input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            do_rise(d, hi, lo);
            repeat (hi) @(negedge clk);
            sig[d] = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic wait_stall(input int d, input int maxc, input logic st);
        while (cyc < rise_k[d] + 1 + maxc) @(negedge clk);
        chk($sformatf("stall_early[%0d]", d), int'(st), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_period", int'(ifa.period), 0);
        chk("rst_high", int'(ifa.high_time), 0);
        chk("rst_valid", int'(ifa.valid), 0);
        chk("rst_stalled", int'(ifa.stalled), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 5, 5, 4);
        run(0, 3, 12, 3);
        run(0, 1, 1, 4);
        run(0, 5, 5, 3);
        armed[0] = 1'b0;
        wait_stall(0, 100, ifa.stalled);
        chk("stall_early_a", int'(ifa.stalled), 0);
        @(negedge clk);
        chk("stall_at_100", int'(ifa.stalled), 1);
        repeat (5) @(negedge clk);
        run(0, 5, 5, 3);
        chk("stall_cleared", int'(ifa.stalled), 0);

        do_rise(0, 5, 5);
        repeat (5) @(negedge clk);
        sig[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        armed[0] = 1'b0;
        chk("mid_rst_period", int'(ifa.period), 0);
        chk("mid_rst_high", int'(ifa.high_time), 0);
        chk("mid_rst_valid", int'(ifa.valid), 0);
        chk("mid_rst_stalled", int'(ifa.stalled), 0);
        repeat (2) @(negedge clk);
        run(0, 5, 5, 3);

        run(1, 10, 10, 5);
        do_rise(1, 10, 10);
        repeat (10) @(negedge clk);
        sig[1] = 1'b0;
        armed[1] = 1'b0;
        chk("boundary_stalled", int'(ifb.stalled), 0);

        run(2, 5, 5, 2);
        do_rise(2, 5, 5);
        armed[2] = 1'b0;
        while (cyc < rise_k[2] + 1 + 50) @(negedge clk);
        chk("stuck_early", int'(ifc.stalled), 0);
        @(negedge clk);
        chk("stuck_at_50", int'(ifc.stalled), 1);
        chk("stuck_period", int'(ifc.period), 10);
        chk("stuck_high", int'(ifc.high_time), 5);
        sig[2] = 1'b0;

        repeat (5) @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous periodic signal, such as a divided clock or the ADC joystick sample strobe, in `clk_in` cycles. It publishes each measurement with a one-cycle valid strobe. A sticky flag reports a stalled input when no edge arrives within a timeout. It is the receive-side check for the clock-divider block: it sits on the divider output, or on any external strobe, and reports what frequency actually arrives.

## Interface
- `W`, default 16: counter and result width.
- `MAX_CNT`, default 2**W-1: timeout in `clk_in` cycles without a rising edge. Legal range is 4..2**W-1.
- `clk_in`, input, 1: the only clock. Everything is sampled on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `sig_in`, input, 1: asynchronous signal to be measured.
- `period`, output, W: `clk_in` cycles between the last two rising edges of the synchronized signal.
- `high_time`, output, W: `clk_in` cycles the synchronized signal was high within that period.
- `valid`, output, 1: one-cycle pulse when `period` and `high_time` update.
- `stalled`, output, 1: sticky flag. Set on timeout; cleared on the next `valid`.

## Operation
- Input conditioning:
  - `sig_in` passes through a 2-flop synchronizer, `s1` then `s2`, plus a delay flop `sd`.
  - Rising edge: `rise = s2 & ~sd`. Falling edge: `fall = ~s2 & sd`.
  - Every internal decision uses `s2`, `rise` and `fall` only.
- Internal registers:
  - `cnt` (W bits): cycles since the last rise.
  - `hcnt` (W bits): high cycles since the last rise.
  - `hlat` (W bits): `hcnt` captured at the fall.
  - `seen_fall` (1 bit).
- States:
  - **IDLE**: waiting for the first rise. Counters are held at 0.
    - On `rise`: `cnt <= 1`, `hcnt <= 1`, `seen_fall <= 0`, go to MEASURE.
  - **MEASURE**, on each cycle without a rise:
    - `cnt <= cnt + 1`.
    - `hcnt <= hcnt + 1` if `s2 == 1`.
    - On `fall`: `hlat <= hcnt`, `seen_fall <= 1`.
  - **MEASURE**, on `rise`:
    - `period <= cnt`.
    - `high_time <= seen_fall ? hlat : hcnt`.
    - `valid <= 1`, `stalled <= 0`.
    - Restart: `cnt <= 1`, `hcnt <= 1`, `seen_fall <= 0`. Stay in MEASURE.
  - **MEASURE**, when `cnt == MAX_CNT` and there is no rise in that cycle:
    - `stalled <= 1`, then go to IDLE.
    - `period` and `high_time` are not changed and `valid` is not pulsed.
- Simultaneous rise and `cnt == MAX_CNT`: the rise wins. `period = MAX_CNT`, `valid` pulses and there is no stall.
- Counter width: `cnt` can never exceed `MAX_CNT`, so there is no wrap-around. `hcnt` ≤ `cnt` holds by construction.
- After a stall, the next rise re-enters MEASURE without a `valid`. The first `valid` after a stall comes on the second rise.
- Reset, including reset in the middle of a measurement:
  - All of these return to 0: synchronizer flops, `cnt`, `hcnt`, `hlat`, `seen_fall`, `period`, `high_time`, `valid`, `stalled`.
  - State returns to IDLE.
  - A partial measurement is discarded.

## Timing
- Reset values: `period = 0`, `high_time = 0`, `valid = 0`, `stalled = 0`.
- Input latency:
  - `sig_in` is first sampled high at clock edge k.
  - `s2 = 1` after edge k+1.
  - `rise` is asserted in the cycle that follows, and is acted on at edge k+2.
- `valid` is registered. It is high for exactly one cycle, starting the cycle after the edge where the second (or any later) rise is acted on.
- `period` and `high_time` change only together with `valid`. They hold their values otherwise.
- Measurement validity: `period` is exact for any input whose high and low phases each last at least 1 `clk_in` cycle as seen at `s2`. The minimum measurable period is 2.
- Throughput: one result per input period; there is no backpressure.
- `stalled` rises exactly `MAX_CNT` cycles after the last rise was acted on.

## Test plan
- **Divider-rate input**: `sig_in` high for 5 cycles, low for 5, repeated (synchronous to `clk_in`).
  - First `valid` comes on the second rise; none on the first.
  - Thereafter `valid` pulses every 10 cycles with `period = 10`, `high_time = 5`.
- **Asymmetric duty**: high 3, low 12.
  - `period = 15`, `high_time = 3` on every `valid`.
  - Then switch to high 1, low 1: `period = 2`, `high_time = 1`.
- **Timeout**: `MAX_CNT = 100`; run 3 periods of 10, then hold `sig_in` low.
  - `stalled = 1` exactly 100 cycles after the last rise.
  - Resume toggling: no `valid` on the first rise; the second rise gives `valid`, `stalled = 0`, `period = 10`.
- **Boundary**: `MAX_CNT = 20`, input period exactly 20.
  - `valid` on every rise with `period = 20`; `stalled` stays 0.
- **Reset mid-operation**: assert `rst_n = 0` for 1 cycle at cycle 7 of a 10-cycle period.
  - All outputs read 0 on the next cycle.
  - The next `valid` comes only after two further rises, with `period = 10`.
- **Stuck high**: `MAX_CNT = 50`, `sig_in` held high after a rise.
  - `stalled = 1` at 50 cycles; `period` and `high_time` keep their prior values.
